// File: rtl/mem_stage.sv
// Pipeline memory stage: branch resolution against the fetch prediction and
// load/store sequencing over a req/ack data port with a bounded timeout.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_in,
    input  logic [31:0] PC_plus_X_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] read_data2_in,
    input  logic [4:0]  rd_in,
    input  logic        zero_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic        memToReg_in,
    input  logic        regWrite_in,
    input  logic        prediction_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        bp_update,
    output logic        bp_taken,
    output logic [31:0] bp_pc,
    output logic        mem_err,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_rd,
    output logic        wb_regWrite,
    output logic        wb_memToReg
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d, err_q, err_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [4:0]    rd_q, rd_d;
    logic          regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
    logic [31:0]   wb_mem_data_q, wb_mem_data_d, wb_alu_q, wb_alu_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_regwrite_q, wb_regwrite_d, wb_memtoreg_q, wb_memtoreg_d;

    logic mem_op, misaligned, timeout, taken, is_idle;

    always_comb begin
        is_idle    = (state_q == IDLE);
        mem_op     = memRead_in | memWrite_in;
        misaligned = (ALU_result_in[1:0] != 2'b00);
        timeout    = (state_q == ACCESS) && (cnt_q == CW'(TIMEOUT - 1));
        taken      = jump_in | (branch_in & zero_in);

        // Resolution is only meaningful for a live instruction in IDLE.
        flush       = is_idle & (branch_in | jump_in) & (taken != prediction_in);
        redirect_pc = taken ? PC_plus_X_in : PC_in + 32'd4;
        bp_update   = is_idle & branch_in;
        bp_taken    = is_idle & taken;
        bp_pc       = PC_in;
        stall       = (is_idle & mem_op) | (~is_idle & ~dmem_ack & ~timeout);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        // MEM/WB carries a bubble unless something completes this cycle.
        wb_mem_data_d = 32'd0;
        wb_alu_d      = 32'd0;
        wb_rd_d       = 5'd0;
        wb_regwrite_d = 1'b0;
        wb_memtoreg_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        req_d      = 1'b1;
                        cnt_d      = '0;
                        we_d       = memWrite_in;
                        addr_d     = ALU_result_in;
                        wdata_d    = read_data2_in;
                        rd_d       = rd_in;
                        regwrite_d = regWrite_in;
                        memtoreg_d = memToReg_in;
                    end
                end else begin
                    wb_alu_d      = ALU_result_in;
                    wb_rd_d       = rd_in;
                    wb_regwrite_d = regWrite_in;
                    wb_memtoreg_d = memToReg_in;
                end
            end
            ACCESS: begin
                if (dmem_ack || timeout) begin
                    state_d       = IDLE;
                    req_d         = 1'b0;
                    cnt_d         = '0;
                    wb_mem_data_d = (dmem_ack && !we_q) ? dmem_rdata : 32'd0;
                    wb_alu_d      = addr_q;
                    wb_rd_d       = rd_q;
                    wb_regwrite_d = regwrite_q;
                    wb_memtoreg_d = memtoreg_q;
                    if (!dmem_ack) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            rd_q          <= 5'd0;
            regwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            wb_mem_data_q <= 32'd0;
            wb_alu_q      <= 32'd0;
            wb_rd_q       <= 5'd0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            err_q         <= err_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_q          <= rd_d;
            regwrite_q    <= regwrite_d;
            memtoreg_q    <= memtoreg_d;
            wb_mem_data_q <= wb_mem_data_d;
            wb_alu_q      <= wb_alu_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_err       = err_q;
    assign wb_mem_data   = wb_mem_data_q;
    assign wb_alu_result = wb_alu_q;
    assign wb_rd         = wb_rd_q;
    assign wb_regWrite   = wb_regwrite_q;
    assign wb_memToReg   = wb_memtoreg_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4; expected values hand-computed.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_in, PC_plus_X_in, ALU_result_in, read_data2_in;
    logic [4:0]  rd_in;
    logic        zero_in, branch_in, jump_in, memRead_in, memWrite_in;
    logic        memToReg_in, regWrite_in, prediction_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, flush, bp_update, bp_taken, mem_err;
    logic [31:0] redirect_pc, bp_pc, wb_mem_data, wb_alu_result;
    logic [4:0]  wb_rd;
    logic        wb_regWrite, wb_memToReg;

    int total = 0;
    int bad   = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .PC_in(PC_in), .PC_plus_X_in(PC_plus_X_in),
        .ALU_result_in(ALU_result_in), .read_data2_in(read_data2_in),
        .rd_in(rd_in), .zero_in(zero_in), .branch_in(branch_in),
        .jump_in(jump_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .memToReg_in(memToReg_in), .regWrite_in(regWrite_in),
        .prediction_in(prediction_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .bp_update(bp_update), .bp_taken(bp_taken), .bp_pc(bp_pc),
        .mem_err(mem_err), .wb_mem_data(wb_mem_data),
        .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bubble();
        PC_in = 32'd0; PC_plus_X_in = 32'd0; ALU_result_in = 32'd0;
        read_data2_in = 32'd0; rd_in = 5'd0; zero_in = 0; branch_in = 0;
        jump_in = 0; memRead_in = 0; memWrite_in = 0; memToReg_in = 0;
        regWrite_in = 0; prediction_in = 0;
    endtask

    // Advance to the next cycle; inputs change 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] addr, input logic [4:0] rd);
        bubble();
        ALU_result_in = addr; memRead_in = 1; memToReg_in = 1;
        regWrite_in = 1; rd_in = rd;
    endtask

    initial begin
        bubble();
        dmem_ack = 0; dmem_rdata = 32'd0;
        rst = 1;
        #2;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        chk("rst_wb_alu", wb_alu_result, 32'd0);
        chk("rst_wb_rw", {31'd0, wb_regWrite}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Non-memory op: one-cycle latency into MEM/WB.
        next_cycle();
        ALU_result_in = 32'h10; rd_in = 5'd5; regWrite_in = 1;
        @(negedge clk);
        chk("nm_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        bubble();
        @(negedge clk);
        chk("nm_wb_alu", wb_alu_result, 32'h10);
        chk("nm_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("nm_wb_rw", {31'd0, wb_regWrite}, 32'd1);
        chk("nm_wb_md", wb_mem_data, 32'd0);
        chk("nm_stall2", {31'd0, stall}, 32'd0);

        // Load acknowledged in cycle 3.
        next_cycle();
        start_load(32'h40, 5'd7);
        @(negedge clk);
        chk("ld_c0_stall", {31'd0, stall}, 32'd1);
        chk("ld_c0_req", {31'd0, dmem_req}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 3) begin dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; end
            @(negedge clk);
            chk($sformatf("ld_c%0d_req", c), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("ld_c%0d_stall", c), {31'd0, stall}, (c < 3) ? 32'd1 : 32'd0);
        end
        chk("ld_addr", dmem_addr, 32'h40);
        chk("ld_we", {31'd0, dmem_we}, 32'd0);
        next_cycle();
        dmem_ack = 0; dmem_rdata = 32'd0; bubble();
        @(negedge clk);
        chk("ld_wb_md", wb_mem_data, 32'hDEADBEEF);
        chk("ld_wb_rd", {27'd0, wb_rd}, 32'd7);
        chk("ld_wb_rw", {31'd0, wb_regWrite}, 32'd1);
        chk("ld_wb_m2r", {31'd0, wb_memToReg}, 32'd1);
        chk("ld_req_off", {31'd0, dmem_req}, 32'd0);
        chk("ld_err", {31'd0, mem_err}, 32'd0);

        // Ack arriving in the timeout cycle (cycle 4) wins.
        next_cycle();
        start_load(32'h44, 5'd9);
        for (int c = 1; c <= 4; c++) next_cycle();
        dmem_ack = 1; dmem_rdata = 32'hCAFE0001;
        @(negedge clk);
        chk("race_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        dmem_ack = 0; bubble();
        @(negedge clk);
        chk("race_wb_md", wb_mem_data, 32'hCAFE0001);
        chk("race_wb_rd", {27'd0, wb_rd}, 32'd9);
        chk("race_err", {31'd0, mem_err}, 32'd0);

        // Branch / jump resolution.
        PC_in = 32'h100; PC_plus_X_in = 32'h120;
        branch_in = 1; zero_in = 1; prediction_in = 0;
        #1;
        chk("br_flush", {31'd0, flush}, 32'd1);
        chk("br_redir", redirect_pc, 32'h120);
        chk("br_upd", {31'd0, bp_update}, 32'd1);
        chk("br_taken", {31'd0, bp_taken}, 32'd1);
        chk("br_pc", bp_pc, 32'h100);
        chk("br_stall", {31'd0, stall}, 32'd0);
        prediction_in = 1;
        #1;
        chk("br_ok_flush", {31'd0, flush}, 32'd0);
        zero_in = 0;
        #1;
        chk("brnt_flush", {31'd0, flush}, 32'd1);
        chk("brnt_redir", redirect_pc, 32'h104);
        chk("brnt_taken", {31'd0, bp_taken}, 32'd0);
        branch_in = 0; jump_in = 1; prediction_in = 0;
        #1;
        chk("jmp_flush", {31'd0, flush}, 32'd1);
        chk("jmp_upd", {31'd0, bp_update}, 32'd0);
        chk("jmp_redir", redirect_pc, 32'h120);

        // Misaligned load.
        next_cycle();
        start_load(32'h42, 5'd3);
        @(negedge clk);
        chk("mis_stall0", {31'd0, stall}, 32'd1);
        next_cycle();
        bubble();
        @(negedge clk);
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_err", {31'd0, mem_err}, 32'd1);
        chk("mis_stall1", {31'd0, stall}, 32'd0);
        chk("mis_wb_rw", {31'd0, wb_regWrite}, 32'd0);

        // Store never acknowledged: abort in cycle 4.
        next_cycle();
        bubble();
        ALU_result_in = 32'h80; read_data2_in = 32'h1234; memWrite_in = 1;
        @(negedge clk);
        chk("st_c0_stall", {31'd0, stall}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("st_c%0d_req", c), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("st_c%0d_stall", c), {31'd0, stall}, (c < 4) ? 32'd1 : 32'd0);
        end
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_wdata", dmem_wdata, 32'h1234);
        chk("st_addr", dmem_addr, 32'h80);
        next_cycle();
        bubble();
        @(negedge clk);
        chk("st_c5_req", {31'd0, dmem_req}, 32'd0);
        chk("st_c5_err", {31'd0, mem_err}, 32'd1);
        chk("st_c5_wb_rw", {31'd0, wb_regWrite}, 32'd0);
        chk("st_c5_wb_md", wb_mem_data, 32'd0);

        // Reset in cycle 2 of an outstanding load; later stray ack ignored.
        next_cycle();
        start_load(32'h50, 5'd11);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rsta_req_pre", {31'd0, dmem_req}, 32'd1);
        rst = 1;
        #1;
        chk("rsta_req", {31'd0, dmem_req}, 32'd0);
        chk("rsta_err", {31'd0, mem_err}, 32'd0);
        chk("rsta_wb_rd", {27'd0, wb_rd}, 32'd0);
        bubble();
        @(negedge clk);
        rst = 0;
        next_cycle();
        dmem_ack = 1; dmem_rdata = 32'h55AA55AA;
        next_cycle();
        dmem_ack = 0;
        @(negedge clk);
        chk("stray_wb_md", wb_mem_data, 32'd0);
        chk("stray_wb_rw", {31'd0, wb_regWrite}, 32'd0);
        chk("stray_req", {31'd0, dmem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, consuming the EX/MEM pipeline register outputs and producing the MEM/WB register. It resolves branches and jumps against the fetch-time prediction, drives flush/redirect and predictor update, and runs load/store traffic over a req/ack data-memory port. The port has variable latency, so the stage stalls upstream while an access is outstanding and aborts it after a bounded timeout.

## Interface
- TIMEOUT, 16: max cycles dmem_req stays high before abort (≥2); counter width $clog2(TIMEOUT).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- PC_in, PC_plus_X_in, ALU_result_in, read_data2_in  in  32 each  from EX/MEM.
- rd_in  in  5; zero_in, branch_in, jump_in, memRead_in, memWrite_in, memToReg_in, regWrite_in, prediction_in  in  1 each  from EX/MEM.
- dmem_req  out  1  access request, held until ack/abort.
- dmem_we  out  1  1 = store.
- dmem_addr, dmem_wdata  out  32  latched ALU_result / read_data2.
- dmem_ack  in  1  access complete (rdata valid same cycle for loads).
- dmem_rdata  in  32  load data.
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- flush  out  1  squash IF/ID and ID/EX.
- redirect_pc  out  32  fetch target when flush=1.
- bp_update, bp_taken  out  1; bp_pc  out  32  predictor training.
- mem_err  out  1  sticky: misaligned access or timeout.
- wb_mem_data, wb_alu_result  out  32; wb_rd  out  5; wb_regWrite, wb_memToReg  out  1  MEM/WB register.

## Operation
- Instruction is live when any of branch/jump/memRead/memWrite/regWrite is 1; all-zero control = bubble.
- FSM states IDLE, ACCESS.
- IDLE, mem_op = memRead_in|memWrite_in, addr[1:0]==0: latch addr, wdata, we=memWrite_in, rd, regWrite, memToReg; go ACCESS. MEM/WB loads bubble (wb_regWrite=0).
- IDLE, mem_op misaligned: set mem_err, no request; MEM/WB loads bubble; stay IDLE.
- IDLE, non-mem: MEM/WB loads wb_alu_result=ALU_result_in, rd, regWrite, memToReg; wb_mem_data=0.
- ACCESS: dmem_req=1 and counter increments each cycle. On dmem_ack: MEM/WB loads dmem_rdata (loads) or 0 (stores) plus latched control; go IDLE, counter clears. When counter==TIMEOUT-1 without ack: abort, set mem_err, MEM/WB loads wb_mem_data=0 with latched control; go IDLE.
- ack and timeout in the same cycle: ack wins, mem_err unchanged.
- stall = (IDLE & mem_op) | (ACCESS & ~dmem_ack & ~timeout). Combinational.
- Branch resolution applies in IDLE only: taken = jump_in | (branch_in & zero_in).
- mispredict = (branch_in|jump_in) & (taken != prediction_in).
- flush = mispredict.
- redirect_pc = taken ? PC_plus_X_in : PC_in+4 (mod 2^32).
- bp_update = branch_in. bp_pc = PC_in. bp_taken = taken.
- Branch/jump never carry mem ops; flush and stall are never both high.
- mem_err clears only on rst.

## Timing
- Reset (async, immediate): state IDLE, counter 0, dmem_req/we/addr/wdata 0, mem_err 0, all wb_* 0. stall/flush/bp_* follow inputs (0 for bubble input).
- Non-mem latency: 1 cycle, inputs → wb_* at next edge.
- Mem op at cycle 0: stall=1 in cycle 0. dmem_req rises cycle 1. Ack in cycle k (k≥1) → wb_* valid cycle k+1. stall=0 in cycle k, so upstream advances at that edge. Minimum 2-cycle latency.
- Timeout: dmem_req high cycles 1..TIMEOUT. Abort and stall=0 in cycle TIMEOUT.
- dmem_addr/wdata/we stable whenever dmem_req=1. Inputs ignored while in ACCESS.
- rst during ACCESS: dmem_req drops without waiting for clock; a later stray ack is ignored in IDLE.

## Test plan
- Non-mem: ALU_result=0x10, rd=5, regWrite=1 → next cycle wb_alu_result=0x10, wb_rd=5, wb_regWrite=1, stall never high.
- Load, ack in req cycle 3: addr 0x40, memRead, memToReg, rd=7, rdata=0xDEADBEEF → stall cycles 0–2, low cycle 3; dmem_req cycles 1–3; cycle 4 wb_mem_data=0xDEADBEEF, wb_rd=7.
- Store, no ack, TIMEOUT=4: addr 0x80, wdata 0x1234 → dmem_we=1, dmem_req cycles 1–4, mem_err=1 from cycle 5, wb_regWrite=0.
- Misaligned load addr 0x42 → no dmem_req, mem_err=1 next cycle, stall cycle 0 only, MEM/WB bubble.
- Branch, zero=1, prediction=0, PC=0x100, PC_plus_X=0x120 → flush=1, redirect_pc=0x120, bp_update=1, bp_taken=1. Same branch with prediction=1 → flush=0.
- Reset asserted in cycle 2 of an outstanding load → dmem_req 0 immediately, all wb_* 0; ack next cycle causes no wb write.
